// File: rtl/pq_pkg.sv
// Shared QuickQ types: key/value record, capacity and sequencer states.
package pq_pkg;
  localparam int KEY_WIDTH   = 16;
  localparam int VAL_WIDTH   = 16;
  localparam int PQ_CAPACITY = 8;

  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } kv_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    PLACE,
    DEQ_RD
  } quickq_seq_state_t;
endpackage

// File: rtl/quickq_seq_if.sv
// Host-side command/status bundle of the QuickQ sequencer.
interface quickq_seq_if
  import pq_pkg::*;
#(
  parameter int CAP = PQ_CAPACITY,
  parameter int SW  = $clog2(CAP + 1)
);
  logic          enq;
  logic          deq;
  kv_t           kvi;
  kv_t           kvo;
  logic          full;
  logic          empty;
  logic          busy;
  logic [SW-1:0] size;

  modport master (output enq, deq, kvi, input kvo, full, empty, busy, size);
  modport slave  (input enq, deq, kvi, output kvo, full, empty, busy, size);
endinterface

// File: rtl/mem2p_sw_sr.sv
// Simple dual-port RAM: one write port, one read port with registered output.
module mem2p_sw_sr
  import pq_pkg::*;
#(
  parameter int DEPTH = PQ_CAPACITY,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  kv_t           din,
  input  logic [AW-1:0] raddr,
  output kv_t           dout
);
  kv_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
    dout <= mem[raddr];
  end
endmodule

// File: rtl/quickq_seq.sv
// QuickQ sequencer: descending sorted array in external BRAM, cached minimum,
// O(1) dequeue and shift-up insertion; commands accepted only while idle.
module quickq_seq
  import pq_pkg::*;
#(
  parameter int CAP = PQ_CAPACITY,
  parameter int AW  = $clog2(CAP),
  parameter int SW  = $clog2(CAP + 1)
) (
  input  logic          clk,
  input  logic          rst,
  quickq_seq_if.slave   host,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output kv_t           mem_din,
  output logic [AW-1:0] mem_raddr,
  input  kv_t           mem_dout
);
  quickq_seq_state_t state;
  logic [SW-1:0]     size;
  kv_t               min_kv;
  kv_t               k;
  logic [AW-1:0]     i;
  logic              rep_pend;

  logic [SW-1:0] size_m1, size_m2;
  logic          is_full, is_empty, idle;
  logic          do_enq, do_deq, do_rep;
  logic          enq_fast, rep_fast, scan_stop, scan_bottom;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  assign size_m1     = size - SW'(1);
  assign size_m2     = size - SW'(2);
  assign is_full     = (size == SW'(CAP));
  assign is_empty    = (size == '0);
  assign idle        = (state == IDLE);
  assign do_rep      = idle && host.enq && host.deq && !is_empty;
  assign do_deq      = idle && host.deq && !host.enq && !is_empty;
  assign do_enq      = idle && host.enq && !do_rep && !is_full;
  assign enq_fast    = is_empty || (host.kvi.key < min_kv.key);
  assign rep_fast    = (host.kvi.key < min_kv.key) || (size == SW'(1));
  assign scan_stop   = (mem_dout.key > k.key);
  // Landing k in the bottom slot after a replace makes it the new minimum.
  assign scan_bottom = ((SW'(i) + SW'(1)) == size_m1);

  assign host.kvo   = min_kv;
  assign host.full  = is_full;
  assign host.empty = is_empty;
  assign host.busy  = !idle;
  assign host.size  = size;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_din   = host.kvi;
    rd_en     = 1'b0;
    rd_addr   = '0;
    case (state)
      IDLE: begin
        if (do_enq && enq_fast) begin
          mem_we    = 1'b1;
          mem_waddr = AW'(size);
        end else if (do_enq) begin
          rd_en   = 1'b1;
          rd_addr = AW'(size_m1);
        end else if (do_rep && rep_fast) begin
          mem_we    = 1'b1;
          mem_waddr = AW'(size_m1);
        end else if ((do_deq || do_rep) && (size > SW'(1))) begin
          rd_en   = 1'b1;
          rd_addr = AW'(size_m2);
        end
      end
      SCAN: begin
        mem_we    = 1'b1;
        mem_waddr = i + AW'(1);
        mem_din   = scan_stop ? k : mem_dout;
        if (!scan_stop && (i != '0)) begin
          rd_en   = 1'b1;
          rd_addr = i - AW'(1);
        end
      end
      PLACE: begin
        mem_we  = 1'b1;
        mem_din = k;
      end
      DEQ_RD: begin
        if (rep_pend) begin
          rd_en   = 1'b1;
          rd_addr = AW'(size_m1);
        end
      end
      default: ;
    endcase
    if (rst) mem_we = 1'b0;
  end

  // Idle read port points away from the write address so the two never collide.
  assign mem_raddr = rd_en ? rd_addr : (mem_waddr ^ AW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      size     <= '0;
      min_kv   <= '0;
      k        <= '0;
      i        <= '0;
      rep_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (do_enq) begin
            size <= size + SW'(1);
            if (enq_fast) begin
              min_kv <= host.kvi;
            end else begin
              k     <= host.kvi;
              i     <= AW'(size_m1);
              state <= SCAN;
            end
          end else if (do_rep) begin
            if (rep_fast) begin
              min_kv <= host.kvi;
            end else begin
              k        <= host.kvi;
              size     <= size_m1;
              rep_pend <= 1'b1;
              state    <= DEQ_RD;
            end
          end else if (do_deq) begin
            size     <= size_m1;
            rep_pend <= 1'b0;
            if (size > SW'(1)) state <= DEQ_RD;
          end
        end
        DEQ_RD: begin
          min_kv <= mem_dout;
          if (rep_pend) begin
            rep_pend <= 1'b0;
            i        <= AW'(size_m1);
            size     <= size + SW'(1);
            state    <= SCAN;
          end else begin
            state <= IDLE;
          end
        end
        SCAN: begin
          if (scan_stop) begin
            if (scan_bottom) min_kv <= k;
            state <= IDLE;
          end else if (i != '0) begin
            i <= i - AW'(1);
          end else begin
            state <= PLACE;
          end
        end
        PLACE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_quickq_seq.sv
// Directed bench for quickq_seq with an attached mem2p_sw_sr.
module tb_quickq_seq;
  import pq_pkg::*;

  localparam int CAP = 8;
  localparam int AW  = $clog2(CAP);
  localparam int SW  = $clog2(CAP + 1);

  logic          clk;
  logic          rst;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  kv_t           mem_din;
  logic [AW-1:0] mem_raddr;
  kv_t           mem_dout;

  int checks = 0;
  int passed = 0;

  quickq_seq_if #(.CAP(CAP), .SW(SW)) qif ();

  quickq_seq #(.CAP(CAP), .AW(AW), .SW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .host      (qif),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_din   (mem_din),
    .mem_raddr (mem_raddr),
    .mem_dout  (mem_dout)
  );

  mem2p_sw_sr #(.DEPTH(CAP), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .din   (mem_din),
    .raddr (mem_raddr),
    .dout  (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (qif.busy && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    qif.enq = 1'b0;
    qif.deq = 1'b0;
    qif.kvi = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic op_enq(input int key, input int val, output int n);
    qif.enq = 1'b1;
    qif.kvi = '{key: KEY_WIDTH'(key), val: VAL_WIDTH'(val)};
    tick();
    qif.enq = 1'b0;
    wait_idle(n);
  endtask

  task automatic op_deq(output kv_t o, output int n);
    qif.deq = 1'b1;
    o = qif.kvo;
    tick();
    qif.deq = 1'b0;
    wait_idle(n);
  endtask

  task automatic op_rep(input int key, input int val, output kv_t o, output int n);
    qif.enq = 1'b1;
    qif.deq = 1'b1;
    qif.kvi = '{key: KEY_WIDTH'(key), val: VAL_WIDTH'(val)};
    o = qif.kvo;
    tick();
    qif.enq = 1'b0;
    qif.deq = 1'b0;
    wait_idle(n);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (qif.empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", qif.empty); else passed++;
    checks++; if (qif.full !== 1'b0) $display("FAIL reset_full: got %b expected 0", qif.full); else passed++;
    checks++; if (qif.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", qif.busy); else passed++;
    checks++; if (qif.size !== 0) $display("FAIL reset_size: got %0d expected 0", qif.size); else passed++;
  endtask

  task automatic test_enq_order();
    int keys[3]     = '{5, 3, 9};
    int exp_busy[3] = '{0, 0, 3};
    int exp_min[3]  = '{5, 3, 3};
    int exp_mem[3]  = '{9, 5, 3};
    int n;
    do_reset();
    for (int j = 0; j < 3; j++) begin
      op_enq(keys[j], j, n);
      checks++; if (n !== exp_busy[j]) $display("FAIL enq_busy[%0d]: got %0d expected %0d", j, n, exp_busy[j]); else passed++;
      checks++; if (qif.kvo.key !== exp_min[j]) $display("FAIL enq_kvo[%0d]: got %0d expected %0d", j, qif.kvo.key, exp_min[j]); else passed++;
    end
    for (int j = 0; j < 3; j++) begin
      checks++; if (u_mem.mem[j].key !== exp_mem[j]) $display("FAIL enq_mem[%0d]: got %0d expected %0d", j, u_mem.mem[j].key, exp_mem[j]); else passed++;
    end
    checks++; if (qif.size !== 3) $display("FAIL enq_size: got %0d expected 3", qif.size); else passed++;
  endtask

  task automatic test_fifo_ties();
    int exp_busy[3] = '{1, 1, 0};
    int exp_val[3]  = '{10, 11, 12};
    int n;
    kv_t o;
    do_reset();
    for (int j = 0; j < 3; j++) op_enq(7, exp_val[j], n);
    for (int j = 0; j < 3; j++) begin
      op_deq(o, n);
      checks++; if (o.val !== exp_val[j]) $display("FAIL tie_val[%0d]: got %0d expected %0d", j, o.val, exp_val[j]); else passed++;
      checks++; if (n !== exp_busy[j]) $display("FAIL tie_busy[%0d]: got %0d expected %0d", j, n, exp_busy[j]); else passed++;
    end
    checks++; if (qif.empty !== 1'b1) $display("FAIL tie_empty: got %b expected 1", qif.empty); else passed++;
  endtask

  task automatic test_full();
    int n;
    kv_t o;
    do_reset();
    for (int j = 1; j <= 8; j++) op_enq(j, j, n);
    checks++; if (qif.full !== 1'b1) $display("FAIL full_flag: got %b expected 1", qif.full); else passed++;
    qif.enq = 1'b1;
    qif.kvi = '{key: KEY_WIDTH'(0), val: VAL_WIDTH'(99)};
    tick();
    qif.enq = 1'b0;
    checks++; if (qif.busy !== 1'b0) $display("FAIL full_enq_busy: got %b expected 0", qif.busy); else passed++;
    checks++; if (qif.size !== 8) $display("FAIL full_enq_size: got %0d expected 8", qif.size); else passed++;
    checks++; if (qif.kvo.key !== 1) $display("FAIL full_enq_kvo: got %0d expected 1", qif.kvo.key); else passed++;
    op_rep(0, 50, o, n);
    checks++; if (o.key !== 1) $display("FAIL full_rep_out: got %0d expected 1", o.key); else passed++;
    checks++; if (n !== 0) $display("FAIL full_rep_busy: got %0d expected 0", n); else passed++;
    checks++; if (qif.kvo.key !== 0) $display("FAIL full_rep_kvo: got %0d expected 0", qif.kvo.key); else passed++;
    checks++; if (qif.full !== 1'b1) $display("FAIL full_rep_full: got %b expected 1", qif.full); else passed++;
    checks++; if (u_mem.mem[7].key !== 0) $display("FAIL full_rep_mem7: got %0d expected 0", u_mem.mem[7].key); else passed++;
  endtask

  task automatic test_replace_slow();
    int exp_a[3] = '{6, 5, 4};
    int exp_b[3] = '{6, 4, 3};
    int n;
    kv_t o;
    do_reset();
    op_enq(2, 0, n); op_enq(4, 0, n); op_enq(6, 0, n);
    op_rep(5, 0, o, n);
    checks++; if (o.key !== 2) $display("FAIL rep5_out: got %0d expected 2", o.key); else passed++;
    checks++; if (n !== 3) $display("FAIL rep5_busy: got %0d expected 3", n); else passed++;
    checks++; if (qif.kvo.key !== 4) $display("FAIL rep5_kvo: got %0d expected 4", qif.kvo.key); else passed++;
    for (int j = 0; j < 3; j++) begin
      checks++; if (u_mem.mem[j].key !== exp_a[j]) $display("FAIL rep5_mem[%0d]: got %0d expected %0d", j, u_mem.mem[j].key, exp_a[j]); else passed++;
    end
    // New key lands below the new minimum.
    do_reset();
    op_enq(2, 0, n); op_enq(4, 0, n); op_enq(6, 0, n);
    op_rep(3, 0, o, n);
    checks++; if (n !== 2) $display("FAIL rep3_busy: got %0d expected 2", n); else passed++;
    checks++; if (qif.kvo.key !== 3) $display("FAIL rep3_kvo: got %0d expected 3", qif.kvo.key); else passed++;
    checks++; if (qif.size !== 3) $display("FAIL rep3_size: got %0d expected 3", qif.size); else passed++;
    for (int j = 0; j < 3; j++) begin
      checks++; if (u_mem.mem[j].key !== exp_b[j]) $display("FAIL rep3_mem[%0d]: got %0d expected %0d", j, u_mem.mem[j].key, exp_b[j]); else passed++;
    end
  endtask

  task automatic test_ignored();
    int exp_mem[4] = '{9, 6, 4, 2};
    int n;
    do_reset();
    qif.deq = 1'b1;
    tick();
    qif.deq = 1'b0;
    checks++; if (qif.size !== 0) $display("FAIL ign_deq_size: got %0d expected 0", qif.size); else passed++;
    checks++; if (qif.busy !== 1'b0) $display("FAIL ign_deq_busy: got %b expected 0", qif.busy); else passed++;
    op_enq(2, 0, n); op_enq(4, 0, n); op_enq(6, 0, n);
    qif.enq = 1'b1;
    qif.kvi = '{key: KEY_WIDTH'(9), val: VAL_WIDTH'(0)};
    tick();
    qif.kvi = '{key: KEY_WIDTH'(1), val: VAL_WIDTH'(1)};
    qif.deq = 1'b1;
    tick();
    tick();
    qif.enq = 1'b0;
    qif.deq = 1'b0;
    wait_idle(n);
    checks++; if (n !== 2) $display("FAIL ign_tail_busy: got %0d expected 2", n); else passed++;
    checks++; if (qif.size !== 4) $display("FAIL ign_size: got %0d expected 4", qif.size); else passed++;
    checks++; if (qif.kvo.key !== 2) $display("FAIL ign_kvo: got %0d expected 2", qif.kvo.key); else passed++;
    for (int j = 0; j < 4; j++) begin
      checks++; if (u_mem.mem[j].key !== exp_mem[j]) $display("FAIL ign_mem[%0d]: got %0d expected %0d", j, u_mem.mem[j].key, exp_mem[j]); else passed++;
    end
  endtask

  task automatic test_reset_mid_scan();
    int n;
    do_reset();
    op_enq(1, 0, n); op_enq(2, 0, n); op_enq(3, 0, n);
    qif.enq = 1'b1;
    qif.kvi = '{key: KEY_WIDTH'(9), val: VAL_WIDTH'(0)};
    tick();
    qif.enq = 1'b0;
    checks++; if (qif.busy !== 1'b1) $display("FAIL mid_busy_before: got %b expected 1", qif.busy); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (qif.busy !== 1'b0) $display("FAIL mid_busy: got %b expected 0", qif.busy); else passed++;
    checks++; if (qif.empty !== 1'b1) $display("FAIL mid_empty: got %b expected 1", qif.empty); else passed++;
    checks++; if (qif.size !== 0) $display("FAIL mid_size: got %0d expected 0", qif.size); else passed++;
    op_enq(3, 0, n);
    checks++; if (qif.kvo.key !== 3) $display("FAIL mid_enq_kvo: got %0d expected 3", qif.kvo.key); else passed++;
  endtask

  initial begin
    rst     = 1'b1;
    qif.enq = 1'b0;
    qif.deq = 1'b0;
    qif.kvi = '0;
    test_reset();
    test_enq_order();
    test_fifo_ties();
    test_full();
    test_replace_slow();
    test_ignored();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
